// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blank mask.
module seq_binary_to_bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]       state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic             sov_q, sov_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DW-1:0]    adj;
  logic [DW-1:0]    dig_sh;
  logic [BIN_W-1:0] sr_sh;
  logic             sov_sh;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step; the bit leaving the top digit is sticky overflow.
  always_comb begin
    dig_sh = {adj[DW-2:0], sr_q[BIN_W-1]};
    sr_sh  = {sr_q[BIN_W-2:0], 1'b0};
    sov_sh = sov_q | adj[DW-1];
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_c;
  logic              nz;

  // Digit i blanks when it and every digit above it are zero; units never blank.
  always_comb begin
    blank_c = '0;
    nz      = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz         = nz | (|dig_sh[4*i +: 4]);
      blank_c[i] = ~nz;
    end
  end
`endif

  // Control and datapath next-state.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    sov_d   = sov_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef BCD_BLANK_EN
    blank_d = blank_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = binary;
          dig_d   = '0;
          sov_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_sh;
        dig_d = dig_sh;
        sov_d = sov_sh;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          bcd_d   = dig_sh;
          ovf_d   = sov_sh;
          done_d  = 1'b1;
`ifdef BCD_BLANK_EN
          blank_d = blank_c;
`endif
        end
      end
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      dig_q   <= '0;
      sov_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      sov_q   <= sov_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_BLANK_EN
  // Blank mask is updated together with bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Randomised self-checking bench for seq_binary_to_bcd.
// Three instances: 8b/3 digits, 16b/5 digits, 8b/2 digits.
module tb_seq_binary_to_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st_a, st_b, st_c;
  logic [7:0]  bin_a, bin_c;
  logic [15:0] bin_b;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [11:0] bcd_a;
  logic [19:0] bcd_b;
  logic [7:0]  bcd_c;
`ifdef BCD_BLANK_EN
  logic [2:0]  blk_a;
  logic [4:0]  blk_b;
  logic [1:0]  blk_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  seq_binary_to_bcd #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef BCD_BLANK_EN
    , .blank(blk_a)
`endif
  );

  seq_binary_to_bcd #(.BIN_W(16), .DIGITS(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef BCD_BLANK_EN
    , .blank(blk_b)
`endif
  );

  seq_binary_to_bcd #(.BIN_W(8), .DIGITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .binary(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
`ifdef BCD_BLANK_EN
    , .blank(blk_c)
`endif
  );

  function automatic int width_of(int idx);
    return (idx == 1) ? 16 : 8;
  endfunction

  function automatic int digits_of(int idx);
    if (idx == 0) return 3;
    if (idx == 1) return 5;
    return 2;
  endfunction

  function automatic logic [39:0] cur_bcd(int idx);
    if (idx == 0) return 40'(bcd_a);
    if (idx == 1) return 40'(bcd_b);
    return 40'(bcd_c);
  endfunction

  function automatic logic cur_done(int idx);
    if (idx == 0) return done_a;
    if (idx == 1) return done_b;
    return done_c;
  endfunction

  function automatic logic cur_busy(int idx);
    if (idx == 0) return busy_a;
    if (idx == 1) return busy_b;
    return busy_c;
  endfunction

  function automatic logic cur_ovf(int idx);
    if (idx == 0) return ovf_a;
    if (idx == 1) return ovf_b;
    return ovf_c;
  endfunction

`ifdef BCD_BLANK_EN
  function automatic logic [9:0] cur_blank(int idx);
    if (idx == 0) return 10'(blk_a);
    if (idx == 1) return 10'(blk_b);
    return 10'(blk_c);
  endfunction
`endif

  // Reference model: plain decimal arithmetic.
  function automatic longint pow10(int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [39:0] ref_bcd(longint v, int d);
    logic [39:0] r = '0;
    longint m = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(longint v, int d);
    return v >= pow10(d);
  endfunction

  function automatic logic [9:0] ref_blank(longint v, int d);
    logic [9:0] r = '0;
    longint m = v % pow10(d);
    for (int i = 1; i < d; i++) r[i] = (m < pow10(i));
    return r;
  endfunction

  task automatic drive(int idx, logic s, longint v);
    if (idx == 0) begin st_a = s; bin_a = 8'(v); end
    else if (idx == 1) begin st_b = s; bin_b = 16'(v); end
    else begin st_c = s; bin_c = 8'(v); end
  endtask

  // Runs one conversion; optionally pokes start while busy.
  task automatic convert(
    input  int          idx,
    input  longint      v,
    input  bit          poke,
    output logic [39:0] got,
    output logic        ovf,
    output int          lat,
    output int          bcnt,
    output bit          held,
    output bit          pulse_ok
  );
    logic [39:0] prev;
    logic        prev_o;
    prev   = cur_bcd(idx);
    prev_o = cur_ovf(idx);
    lat    = 0;
    bcnt   = 0;
    held   = 1'b1;
    drive(idx, 1'b1, v);
    @(negedge clk);
    drive(idx, 1'b0, longint'($urandom));
    while (!cur_done(idx) && lat < 200) begin
      if (cur_busy(idx)) bcnt++;
      if (cur_bcd(idx) !== prev || cur_ovf(idx) !== prev_o) held = 1'b0;
      if (poke && lat == 2) drive(idx, 1'b1, longint'($urandom));
      if (poke && lat == 3) drive(idx, 1'b0, longint'($urandom));
      @(negedge clk);
      lat++;
    end
    got      = cur_bcd(idx);
    ovf      = cur_ovf(idx);
    pulse_ok = !cur_busy(idx);
    @(negedge clk);
    pulse_ok = pulse_ok && !cur_done(idx);
  endtask

  task automatic check_conv(string nm, int idx, longint v, bit poke);
    logic [39:0] got;
    logic        ovf;
    int          lat, bcnt;
    bit          held, pok;
    int          w, d;
    w = width_of(idx);
    d = digits_of(idx);
    convert(idx, v, poke, got, ovf, lat, bcnt, held, pok);
    n_cmp++;
    if (got !== ref_bcd(v, d)) begin
      n_bad++;
      $display("FAIL %s bcd v=%0d got=%h exp=%h", nm, v, got, ref_bcd(v, d));
    end
    n_cmp++;
    if (ovf !== ref_ovf(v, d)) begin
      n_bad++;
      $display("FAIL %s ovf v=%0d got=%b exp=%b", nm, v, ovf, ref_ovf(v, d));
    end
    n_cmp++;
    if (lat != w) begin
      n_bad++;
      $display("FAIL %s latency v=%0d got=%0d exp=%0d", nm, v, lat, w);
    end
    n_cmp++;
    if (bcnt != w) begin
      n_bad++;
      $display("FAIL %s busy_cycles v=%0d got=%0d exp=%0d", nm, v, bcnt, w);
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++;
      $display("FAIL %s hold v=%0d got=%b exp=1", nm, v, held);
    end
    n_cmp++;
    if (pok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done_pulse v=%0d got=%b exp=1", nm, v, pok);
    end
`ifdef BCD_BLANK_EN
    n_cmp++;
    if (cur_blank(idx) !== ref_blank(v, d)) begin
      n_bad++;
      $display("FAIL %s blank v=%0d got=%b exp=%b",
               nm, v, cur_blank(idx), ref_blank(v, d));
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({cur_busy(i), cur_done(i), cur_ovf(i), cur_bcd(i)} !== '0) begin
        n_bad++;
        $display("FAIL reset dut%0d busy=%b done=%b ovf=%b bcd=%h exp all 0",
                 i, cur_busy(i), cur_done(i), cur_ovf(i), cur_bcd(i));
      end
`ifdef BCD_BLANK_EN
      n_cmp++;
      if (cur_blank(i) !== '0) begin
        n_bad++;
        $display("FAIL reset_blank dut%0d got=%b exp=0", i, cur_blank(i));
      end
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_conv("d255", 0, 255, 1'b0);
    check_conv("d0", 0, 0, 1'b0);
    check_conv("d7", 0, 7, 1'b0);
    check_conv("d42", 0, 42, 1'b0);
    check_conv("d65535", 1, 65535, 1'b0);
    check_conv("d199", 2, 199, 1'b0);
    check_conv("d99", 2, 99, 1'b0);
    check_conv("d100_poke", 0, 100, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int     idx;
      longint v;
      idx = int'($urandom_range(0, 2));
      v   = longint'($urandom_range(0, (1 << width_of(idx)) - 1));
      check_conv("rand", idx, v, k[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive(0, 1'b1, 100);
    @(negedge clk);
    drive(0, 1'b1, 33);
    lat = 0;
    while (!done_a && lat < 100) begin
      if (lat == 2) st_a = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 8 || bcd_a !== 12'h100) begin
      n_bad++;
      $display("FAIL b2b_first lat=%0d bcd=%h exp lat=8 bcd=100", lat, bcd_a);
    end
    drive(0, 1'b1, 33);
    @(negedge clk);
    drive(0, 1'b0, longint'($urandom));
    lat = 0;
    while (!done_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 8 || bcd_a !== 12'h033 || ovf_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second lat=%0d bcd=%h ovf=%b exp lat=8 bcd=033 ovf=0",
               lat, bcd_a, ovf_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    check_conv("pre200", 0, 200, 1'b0);
    drive(0, 1'b1, 123);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bcd_a !== 12'h000 || busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset bcd=%h busy=%b done=%b ovf=%b exp all 0",
               bcd_a, busy_a, done_a, ovf_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a || busy_a) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_activity got=%b exp=0", seen);
    end
    check_conv("post123", 0, 123, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_binary_to_bcd.md
Name: seq_binary_to_bcd

Overview:
Multi-cycle, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Replaces the purely combinational converter on score/timer display paths where BIN_W is wide enough to hurt timing.
- Feeds the seven-segment digit drivers.
- Conversion is requested with a start/done handshake; the result is held stable until the next conversion completes.

Parameters:
BIN_W, 8, width of binary input; legal range 4..32.
DIGITS, 3, number of BCD output digits; legal range 1..10.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
start  input  1  conversion request; sampled only in IDLE.
binary  input  BIN_W  value to convert; sampled on the clock edge where start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; bcd/overflow are valid from this cycle.
bcd  output  4*DIGITS  packed result; digit 0 = bcd[3:0] (units).
overflow  output  1  result did not fit in DIGITS digits.

Behaviour:
- Clocking and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE; busy = 0, done = 0, overflow = 0.
  - bcd = 0; internal shift register, scratch digits and bit counter = 0.
- State IDLE:
  - If start = 1 at an edge:
    - latch binary into the shift register;
    - clear the scratch digits and the sticky overflow flag;
    - load bit counter = BIN_W;
    - go to SHIFT; busy = 1.
  - Otherwise stay in IDLE.
- State SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3, applied to all digits in parallel, before the shift.
  - Then shift {scratch digits, shift register} left by one bit.
  - The bit shifted out of the top of digit DIGITS-1 is ORed into the sticky overflow flag.
  - Counter decrements by 1.
- End of conversion: on the edge where the counter goes 1 -> 0:
  - load bcd and overflow from the post-shift scratch values;
  - done = 1 for exactly one cycle; busy = 0;
  - state returns to IDLE.
- Latency: start accepted at edge N -> done high during the cycle after edge N+BIN_W, i.e. BIN_W cycles.
  - Throughput: one conversion per BIN_W cycles.
- Output holding: bcd and overflow hold their previous values during SHIFT and change only on the done edge.
- Back-to-back: state is IDLE while done is high, so start asserted in the done cycle is accepted. The next done follows BIN_W cycles later.
- start while busy: ignored; no queuing; the input value at that edge is not captured.
- binary changes during SHIFT: no effect on the conversion.
- Overflow:
  - When the input value >= 10^DIGITS: overflow = 1 and bcd = value mod 10^DIGITS. This is the natural double-dabble truncation.
  - Otherwise overflow = 0.
- Reset mid-conversion: abort immediately; all outputs return to reset values; no done pulse.
- Arithmetic: each digit add is 4-bit; digit values never exceed 9 after each full step.

Optional Feature:
Macro: BCD_BLANK_EN.
- Defined:
  - Adds output port blank (output, width DIGITS), registered and updated on the done edge together with bcd.
  - blank[i] = 1 when digit i and all higher digits are zero, for i >= 1.
  - blank[0] is always 0, so a value of 0 displays a single "0".
  - Reset value: all zeros.
- Not defined: port absent; no blanking logic; all other behaviour identical.

Test Plan:
- BIN_W=8, DIGITS=3; binary=8'd255, start pulse -> done 8 cycles later; bcd=12'h255, overflow=0; busy high for the 8 intervening cycles.
- BIN_W=8, DIGITS=3; binary=0 -> bcd=12'h000, overflow=0. With BCD_BLANK_EN: blank=3'b110. With binary=8'd7: blank=3'b110. With binary=8'd42: blank=3'b100.
- BIN_W=16, DIGITS=5; binary=16'd65535 -> done after 16 cycles; bcd=20'h65535, overflow=0.
- BIN_W=8, DIGITS=2; binary=8'd199 -> bcd=8'h99, overflow=1. Then binary=8'd99 -> overflow=0, bcd=8'h99.
- Convert 8'd100. Start pulses while busy with 8'd33 are ignored -> single done, bcd=12'h100. A start in the done cycle with 8'd33 is accepted -> second done 8 cycles later, bcd=12'h033.
- Convert 8'd200. After one done pulse (bcd=12'h200), start a conversion of 8'd123; assert rst_n=0 at cycle 4 of SHIFT -> bcd=0, busy=0, done never pulses. After release, converting 8'd123 gives bcd=12'h123.
